// File: rtl/viterbi_frame_scheduler_if.sv
// Frame-in / result-out handshake bundle between the frame scheduler and its neighbours.
interface viterbi_frame_scheduler_if #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 8
);
   logic             in_valid;
   logic [IN_W-1:0]  in_data;
   logic             in_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             out_err;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/viterbi_frame_scheduler.sv
// Queues coded frames, runs them one at a time through a viterbi decoder and
// returns each decoded byte on a valid/ready port, with a watchdog for hung decodes.
module viterbi_frame_scheduler #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned IN_W       = 16,
   parameter int unsigned OUT_W      = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   viterbi_frame_scheduler_if.slave bus,
   output logic                     dec_en,
   output logic                     dec_rst,
   output logic [IN_W-1:0]          dec_data,
   input  logic [OUT_W-1:0]         dec_data_out,
   input  logic                     dec_done,
   output logic                     busy,
   output logic [15:0]              frame_cnt
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t             state, state_d;
   logic [IN_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count, count_d;
   logic [TMR_W-1:0]   timer, timer_d;
   logic               done_q;
   logic               done_edge;
   logic               push, pop;

   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic               out_err_q, out_err_d;
   logic               dec_en_d, dec_rst_d, busy_d;
   logic [IN_W-1:0]    dec_data_d;
   logic [15:0]        frame_cnt_d;

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;

   assign push      = bus.in_valid & in_ready_q;
   assign done_edge = dec_done & ~done_q;

   // Frame storage; contents are don't-care while the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         timer       <= '0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         dec_en      <= 1'b0;
         dec_rst     <= 1'b0;
         dec_data    <= '0;
         busy        <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_d;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count       <= count_d;
         timer       <= timer_d;
         done_q      <= dec_done;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         dec_en      <= dec_en_d;
         dec_rst     <= dec_rst_d;
         dec_data    <= dec_data_d;
         busy        <= busy_d;
         frame_cnt   <= frame_cnt_d;
      end
   end

   // Next-state and registered-output logic; a frame is popped only when it is loaded.
   always_comb begin
      state_d     = state;
      pop         = 1'b0;
      timer_d     = timer;
      dec_en_d    = dec_en;
      dec_rst_d   = 1'b0;
      dec_data_d  = dec_data;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      frame_cnt_d = frame_cnt;

      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               dec_data_d = mem[rd_ptr];
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            dec_rst_d = 1'b1;
            dec_en_d  = 1'b1;
            timer_d   = '0;
            state_d   = S_KICK;
         end
         S_KICK: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer + TMR_W'(1);
            // A done level carried over from KICK has no edge and is ignored.
            if (done_edge) begin
               out_data_d  = dec_data_out;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               dec_en_d    = 1'b0;
               state_d     = S_HOLD;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
               out_data_d  = '0;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               dec_en_d    = 1'b0;
               state_d     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               frame_cnt_d = frame_cnt + 16'd1;
               if (count != '0) begin
                  pop        = 1'b1;
                  dec_data_d = mem[rd_ptr];
                  state_d    = S_LOAD;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      count_d = count;
      if (push && !pop) begin
         count_d = count + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count - CNT_W'(1);
      end

      in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
      busy_d     = (state_d != S_IDLE) || (count_d != '0);
   end
endmodule

// File: tb/tb_viterbi_frame_scheduler.sv
// Directed bench for viterbi_frame_scheduler with a behavioural decoder and a
// transaction-level scoreboard checked on every cycle.
module tb_viterbi_frame_scheduler;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dec_en, dec_rst;
   logic [15:0] dec_data;
   logic [7:0]  dec_data_out = 8'h00;
   logic        dec_done = 1'b0;
   logic        busy;
   logic [15:0] frame_cnt;

   int total;
   int bad;

   viterbi_frame_scheduler_if #(.IN_W(16), .OUT_W(8)) bus ();

   viterbi_frame_scheduler #(
      .FIFO_DEPTH (4),
      .TIMEOUT    (64),
      .IN_W       (16),
      .OUT_W      (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .dec_en       (dec_en),
      .dec_rst      (dec_rst),
      .dec_data     (dec_data),
      .dec_data_out (dec_data_out),
      .dec_done     (dec_done),
      .busy         (busy),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   // Decoder stand-in: frame[3:0]==F never finishes, ==E holds a stale done across
   // the restart, otherwise done rises 8+frame[7:4] cycles after restart with ~frame[15:8].
   int         dc   = 1000;
   logic [3:0] mode = 4'h0;
   int         lat  = 8;
   always @(posedge clk) begin
      #1;
      if (dec_rst === 1'b1) begin
         dc   = 0;
         mode = dec_data[3:0];
         lat  = 8 + int'(dec_data[7:4]);
      end else if (dc < 1000) begin
         dc++;
      end
      if (mode == 4'hF)      dec_done = 1'b0;
      else if (mode == 4'hE) dec_done = (dc < 3) || (dc >= 6);
      else                   dec_done = (dc >= lat);
      dec_data_out = (mode == 4'hE && dc < 3) ? 8'hEE : ~dec_data[15:8];
   end

   // Scoreboard state
   logic [15:0] sent_q[$];
   logic [15:0] exp_q[$];
   int          outstanding;
   logic [15:0] acc_cnt;
   bit          prev_hold;
   logic [7:0]  prev_data;
   logic        prev_err;
   bit          prev_rst;
   int          rst_pulses;

   function automatic logic [7:0] model_byte(input logic [15:0] f);
      return (f[3:0] == 4'hF) ? 8'h00 : ~f[15:8];
   endfunction

   function automatic logic model_err(input logic [15:0] f);
      return (f[3:0] == 4'hF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_model();
      sent_q.delete();
      exp_q.delete();
      outstanding = 0;
      acc_cnt     = '0;
      prev_hold   = 1'b0;
      prev_data   = '0;
      prev_err    = 1'b0;
      prev_rst    = 1'b0;
      rst_pulses  = 0;
   endtask

   task automatic compare_step();
      logic [15:0] f;
      if (rst_n !== 1'b1) return;
      chk("busy", 32'(busy), 32'(outstanding != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(outstanding <= int'(DEPTH)));
      chk("frame_cnt", 32'(frame_cnt), 32'(acc_cnt));
      if (prev_hold) begin
         chk("hold_valid", 32'(bus.out_valid), 32'(1));
         chk("hold_data", 32'(bus.out_data), 32'(prev_data));
         chk("hold_err", 32'(bus.out_err), 32'(prev_err));
      end
      if (bus.out_valid) chk("en_in_hold", 32'(dec_en), 32'(0));
      if (dec_rst) begin
         rst_pulses++;
         chk("rst_pulse_len", 32'(prev_rst), 32'(0));
         chk("en_at_kick", 32'(dec_en), 32'(1));
         chk("load_pending", 32'(sent_q.size() != 0), 32'(1));
         if (sent_q.size() != 0) begin
            f = sent_q.pop_front();
            chk("load_data", 32'(dec_data), 32'(f));
         end
      end
      if (bus.out_valid && bus.out_ready) begin
         chk("result_pending", 32'(exp_q.size() != 0), 32'(1));
         if (exp_q.size() != 0) begin
            f = exp_q.pop_front();
            chk("result_data", 32'(bus.out_data), 32'(model_byte(f)));
            chk("result_err", 32'(bus.out_err), 32'(model_err(f)));
         end
         acc_cnt++;
         outstanding--;
      end
      if (bus.in_valid && bus.in_ready) begin
         sent_q.push_back(bus.in_data);
         exp_q.push_back(bus.in_data);
         outstanding++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_err  = bus.out_err;
      prev_rst  = dec_rst;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!ok && n < budget) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
   endtask

   // which: 0 = dec_rst, 1 = out_valid, 2 = !busy; returns at the matching negedge.
   task automatic wait_for(input int which, input int budget, output int cyc);
      bit hit = 1'b0;
      cyc = 0;
      while (!hit && cyc < budget) begin
         @(negedge clk);
         cyc++;
         case (which)
            0:       hit = dec_rst;
            1:       hit = bus.out_valid;
            default: hit = !busy;
         endcase
      end
      chk("wait_event", 32'(hit), 32'(1));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_tests();
      bit ok;
      int c;
      int n_ok;
      logic [15:0] f;

      // Reset values
      tick();
      tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_out_data", 32'(bus.out_data), 32'(0));
      chk("rst_out_err", 32'(bus.out_err), 32'(0));
      chk("rst_dec_en", 32'(dec_en), 32'(0));
      chk("rst_dec_rst", 32'(dec_rst), 32'(0));
      chk("rst_dec_data", 32'(dec_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
      chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
      rst_n = 1'b1;
      tick();

      // Single frame: latency to restart pulse and to result
      bus.out_ready = 1'b1;
      send(16'hA5C3, 10, ok);
      chk("t2_send", 32'(ok), 32'(1));
      wait_for(0, 20, c);
      chk("t2_rst_latency", 32'(c), 32'(3));
      chk("t2_dec_data", 32'(dec_data), 32'hA5C3);
      wait_for(1, 60, c);
      chk("t2_result_latency", 32'(c), 32'(21));
      chk("t2_out_data", 32'(bus.out_data), 32'h5A);
      chk("t2_out_err", 32'(bus.out_err), 32'(0));
      tick();
      tick();
      chk("t2_frame_cnt", 32'(frame_cnt), 32'(1));

      // Asynchronous reset while the decoder is running
      send(16'h550F, 10, ok);
      chk("t1_send", 32'(ok), 32'(1));
      wait_for(0, 20, c);
      repeat (5) @(negedge clk);
      chk("t1_pre_busy", 32'(busy), 32'(1));
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("t1_dec_en", 32'(dec_en), 32'(0));
      chk("t1_out_valid", 32'(bus.out_valid), 32'(0));
      chk("t1_in_ready", 32'(bus.in_ready), 32'(1));
      chk("t1_frame_cnt", 32'(frame_cnt), 32'(0));
      chk("t1_busy", 32'(busy), 32'(0));
      tick();
      tick();
      rst_n = 1'b1;
      repeat (80) tick();
      chk("t1_no_result", 32'(frame_cnt), 32'(0));

      // Back-pressure: one in flight plus a full FIFO, then drain in order
      bus.out_ready = 1'b0;
      n_ok = 0;
      for (int i = 0; i < 6; i++) begin
         f = {8'(8'h12 + 8'(i * 17)), 4'(i), 4'(i + 1)};
         send(f, (i < 5) ? 10 : 40, ok);
         if (ok) n_ok++;
      end
      chk("t3_accepted", 32'(n_ok), 32'(5));
      chk("t3_in_ready_low", 32'(bus.in_ready), 32'(0));
      c = 0;
      while (frame_cnt != 16'd5 && c < 600) begin
         bus.out_ready = ~bus.out_ready;
         tick();
         c++;
      end
      chk("t3_frame_cnt", 32'(frame_cnt), 32'(5));
      bus.out_ready = 1'b1;
      tick();

      // Watchdog abort followed by a normal decode
      send(16'h770F, 10, ok);
      chk("t4_send_a", 32'(ok), 32'(1));
      send(16'h9C21, 10, ok);
      chk("t4_send_b", 32'(ok), 32'(1));
      wait_for(0, 20, c);
      wait_for(1, 100, c);
      chk("t4_timeout_latency", 32'(c), 32'(65));
      chk("t4_timeout_data", 32'(bus.out_data), 32'h00);
      chk("t4_timeout_err", 32'(bus.out_err), 32'(1));
      wait_for(0, 20, c);
      wait_for(1, 60, c);
      chk("t4_next_latency", 32'(c), 32'(11));
      chk("t4_next_data", 32'(bus.out_data), 32'h63);
      chk("t4_next_err", 32'(bus.out_err), 32'(0));
      tick();

      // Stale done level across the restart
      send(16'h3C2E, 10, ok);
      chk("t5_send", 32'(ok), 32'(1));
      wait_for(0, 20, c);
      wait_for(1, 60, c);
      chk("t5_latency", 32'(c), 32'(7));
      chk("t5_data", 32'(bus.out_data), 32'hC3);
      chk("t5_err", 32'(bus.out_err), 32'(0));
      tick();

      // Streaming ten frames with the sink always ready
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         f = {8'(8'h10 + 8'(i * 17)), 4'(i), 4'(i % 8)};
         send(f, 200, ok);
         chk("t6_send", 32'(ok), 32'(1));
      end
      wait_for(2, 600, c);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'(10));
      chk("t6_rst_pulses", 32'(rst_pulses), 32'(10));
      chk("t6_busy", 32'(busy), 32'(0));
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      clear_model();
      fork
         forever begin
            @(negedge clk);
            compare_step();
         end
         run_tests();
      join_any
      disable fork;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
